alu16: RTL and testbench
========================

ALU16 -- requirements
Module: alu16

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_b  input  1  reset, synchronous and active-low.
REQ-003 start  input  1  operation request, sampled in IDLE only.
REQ-004 s  input  4  opcode: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, others reserved.
REQ-005 inbus  input  16  operand input, two words per operation.
REQ-006 outbus  output  16  result word(s); 0x0000 when no result word is presented.
REQ-007 finish  output  1  one-cycle pulse coincident with the last result word.
REQ-008 negative, zero, carry, overflow  output  1 each  status flags of the last completed operation.

Function
REQ-009 Operand sequence: edge with start=1 in IDLE latches s (E0); edge E0+1 captures inbus as M; edge E0+2 captures inbus as Q.
REQ-010 ADD result = Q + M (16-bit); SUB result = Q - M, computed as Q + ~M + 1.
REQ-011 MUL: signed two's-complement 16x16 -> 32-bit product Q*M, radix-2 Booth, one iteration per cycle, 16 iterations.
REQ-012 DIV: unsigned Q / M, 16 iterations one per cycle, yielding 16-bit quotient and 16-bit remainder.
REQ-013 DIV by M=0: quotient 0xFFFF, remainder = Q, overflow=1, no hang.
REQ-014 Internal 16-bit accumulator register named a_out (high product word / partial remainder) is kept.
REQ-015 States: IDLE, LOAD_M, LOAD_Q, EXEC, ITER, OUT_HI, OUT_LO; OUT_LO returns to IDLE.
REQ-016 ADD/SUB: EXEC at E0+3, single result word on outbus with finish=1 during cycle after E0+3; back to IDLE.
REQ-017 MUL: ITER 16 cycles, then OUT_HI presents product[31:16] (finish=0), then OUT_LO presents product[15:0] (finish=1).
REQ-018 DIV: ITER 16 cycles, then OUT_HI presents quotient (finish=0), then OUT_LO presents remainder (finish=1).
REQ-019 Reserved opcodes: after LOAD_Q, one word 0x0000 with finish=1, zero=1, other flags 0.
REQ-020 start asserted outside IDLE is ignored; s and inbus changes outside their capture edges are ignored.
REQ-021 negative = MSB of result (MUL: bit 31; DIV: quotient bit 15).
REQ-022 zero = 1 iff whole result is zero (MUL: all 32 bits; DIV: quotient).
REQ-023 carry: ADD carry-out of bit 15; SUB carry-out of Q+~M+1 (1 = no borrow); MUL/DIV 0.
REQ-024 overflow: ADD/SUB signed overflow; MUL 1 iff product not representable in 16 signed bits; DIV only per REQ-013.
REQ-025 Flags update when finish asserts and hold until next finish or reset.

Reset
REQ-026 rst_b=0 at a rising edge: state IDLE, outbus=0, finish=0, all flags 0, all operand/accumulator registers 0.
REQ-027 Reset mid-operation aborts it; no finish is produced for the aborted operation.

Configuration
REQ-028 Macro ALU_DIV_EN defined: DIV implemented per REQ-012/013/018.
REQ-029 ALU_DIV_EN undefined: divider logic absent; opcode 0011 handled as reserved per REQ-019.

Verification
REQ-030 ADD M=0x0863, Q=0x0005 -> outbus 0x0868, finish one cycle, N=0 Z=0 C=0 V=0.
REQ-031 SUB M=0x0005, Q=0x0863 -> 0x085E, C=1 V=0; SUB M=0x0001, Q=0x8000 -> 0x7FFF, V=1 C=1 N=0.
REQ-032 ADD M=16389, Q=16386 -> 0x8007, N=1 V=1 C=0.
REQ-033 MUL M=2147, Q=5 -> words 0x0000 then 0x29EF; MUL M=2350, Q=159 -> 0x0005 then 0xB392, V=1.
REQ-034 DIV M=145, Q=18921 -> quotient 0x0082 then remainder 0x0047; DIV M=0, Q=7 -> 0xFFFF, 0x0007, V=1.
REQ-035 Reset asserted during MUL ITER -> outbus=0, flags 0, no finish; next ADD runs normally.

Source files
------------

// File: rtl/alu16.sv
// Sequential 16-bit ALU: ADD/SUB in one execute cycle, Booth multiply and restoring divide over 16 cycles.
// Define ALU_DIV_EN to build the divider; without it opcode 0011 behaves as a reserved opcode.
module alu16 (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic [3:0]  s,
    input  logic [15:0] inbus,
    output logic [15:0] outbus,
    output logic        finish,
    output logic        negative,
    output logic        zero,
    output logic        carry,
    output logic        overflow
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, EXEC, ITER, OUT_HI, OUT_LO} state_t;

    state_t      state, nextstate;
    logic [3:0]  opreg;
    logic [15:0] mreg;
    logic [15:0] qreg;
    logic [15:0] a_out;
    logic        q1;
    logic [3:0]  cnt;

    logic        ismul, isdiv, isaddsub, issub;
    logic [15:0] addend;
    logic [16:0] sum17;
    logic [16:0] boothsum;

    assign ismul    = (opreg == OP_MUL);
    assign issub    = (opreg == OP_SUB);
    assign isaddsub = (opreg == OP_ADD) || issub;
`ifdef ALU_DIV_EN
    assign isdiv    = (opreg == OP_DIV);
`else
    assign isdiv    = 1'b0;
`endif

    // SUB reuses the adder as Q + ~M + 1, so carry means "no borrow".
    assign addend = issub ? ~mreg : mreg;
    assign sum17  = {1'b0, qreg} + {1'b0, addend} + {16'd0, issub};

    always_comb begin
        boothsum = {a_out[15], a_out};
        case ({qreg[0], q1})
            2'b10:   boothsum = {a_out[15], a_out} - {mreg[15], mreg};
            2'b01:   boothsum = {a_out[15], a_out} + {mreg[15], mreg};
            default: boothsum = {a_out[15], a_out};
        endcase
    end

`ifdef ALU_DIV_EN
    logic [16:0] divshift;
    logic        divfits;
    assign divshift = {a_out, qreg[15]};
    assign divfits  = (divshift >= {1'b0, mreg});
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= nextstate;
    end

    // Next state plus the result-word mux; outbus is idle-zero outside the two output states.
    always_comb begin
        nextstate = state;
        outbus    = 16'h0000;
        finish    = 1'b0;
        case (state)
            IDLE:    if (start) nextstate = LOAD_M;
            LOAD_M:  nextstate = LOAD_Q;
            LOAD_Q:  nextstate = (ismul || isdiv) ? ITER : EXEC;
            EXEC:    nextstate = OUT_LO;
            ITER:    if (cnt == 4'd15) nextstate = OUT_HI;
            OUT_HI: begin
                nextstate = OUT_LO;
                outbus    = isdiv ? qreg : a_out;
            end
            OUT_LO: begin
                nextstate = IDLE;
                outbus    = isdiv ? a_out : qreg;
                finish    = 1'b1;
            end
            default: nextstate = IDLE;
        endcase
    end

    // Datapath and flags; flags change only on the edge that enters OUT_LO.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            opreg    <= 4'd0;
            mreg     <= 16'd0;
            qreg     <= 16'd0;
            a_out    <= 16'd0;
            q1       <= 1'b0;
            cnt      <= 4'd0;
            negative <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE:   if (start) opreg <= s;
                LOAD_M: mreg <= inbus;
                LOAD_Q: begin
                    qreg  <= inbus;
                    a_out <= 16'd0;
                    q1    <= 1'b0;
                    cnt   <= 4'd0;
                end
                EXEC: begin
                    if (isaddsub) begin
                        qreg     <= sum17[15:0];
                        negative <= sum17[15];
                        zero     <= (sum17[15:0] == 16'd0);
                        carry    <= sum17[16];
                        overflow <= (qreg[15] == addend[15]) && (sum17[15] != qreg[15]);
                    end else begin
                        qreg     <= 16'd0;
                        negative <= 1'b0;
                        zero     <= 1'b1;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                ITER: begin
                    cnt <= cnt + 4'd1;
`ifdef ALU_DIV_EN
                    if (isdiv) begin
                        a_out <= divfits ? 16'(divshift - {1'b0, mreg}) : divshift[15:0];
                        qreg  <= {qreg[14:0], divfits};
                    end else
`endif
                    begin
                        a_out <= boothsum[16:1];
                        qreg  <= {boothsum[0], qreg[15:1]};
                        q1    <= qreg[0];
                    end
                end
                OUT_HI: begin
                    carry <= 1'b0;
                    if (isdiv) begin
                        negative <= qreg[15];
                        zero     <= (qreg == 16'd0);
                        overflow <= (mreg == 16'd0);
                    end else begin
                        negative <= a_out[15];
                        zero     <= ({a_out, qreg} == 32'd0);
                        overflow <= (a_out != {16{qreg[15]}});
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vectors, mid-operation reset and randomized operations
// checked against an arithmetic reference model.
module tb_alu16;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [3:0]  s;
    logic [15:0] inbus;
    logic [15:0] outbus;
    logic        finish;
    logic        negative, zero, carry, overflow;

    int total = 0;
    int fails = 0;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    alu16 dut (
        .clk(clk), .rst_b(rst_b), .start(start), .s(s), .inbus(inbus),
        .outbus(outbus), .finish(finish), .negative(negative), .zero(zero),
        .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected words, flags {N,Z,C,V} and cycles from the Q-capture edge to the finish cycle.
    function automatic void model(input logic [3:0] op, input logic [15:0] m, input logic [15:0] q,
                                  output logic [15:0] hi, output logic [15:0] lo,
                                  output logic [3:0] flg, output bit twoWords, output int lat);
        int sm, sq, u, r;
        longint p;
        logic [31:0] pw;
        sm = int'($signed(m));
        sq = int'($signed(q));
        hi = 16'h0000;
        twoWords = 1'b0;
        lat = 2;
        if (op == 4'd0 || op == 4'd1) begin
            if (op == 4'd0) begin
                u = int'(q) + int'(m);
                r = sq + sm;
                flg[1] = (u > 65535);
            end else begin
                u = int'(q) - int'(m);
                r = sq - sm;
                flg[1] = (q >= m);
            end
            lo = u[15:0];
            flg[3] = lo[15];
            flg[2] = (lo == 16'd0);
            flg[0] = (r > 32767) || (r < -32768);
        end else if (op == 4'd2) begin
            p  = longint'(sq) * longint'(sm);
            pw = p[31:0];
            hi = pw[31:16];
            lo = pw[15:0];
            twoWords = 1'b1;
            lat = 18;
            flg = {p < 0, p == 0, 1'b0, (p > 32767) || (p < -32768)};
        end else if (op == 4'd3 && DIV_EN) begin
            twoWords = 1'b1;
            lat = 18;
            if (m == 16'd0) begin
                hi = 16'hFFFF;
                lo = q;
            end else begin
                hi = q / m;
                lo = q % m;
            end
            flg = {hi[15], hi == 16'd0, 1'b0, m == 16'd0};
        end else begin
            lo  = 16'h0000;
            flg = 4'b0100;
        end
    endfunction

    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [15:0] m,
                                 input logic [15:0] q, input bit pokeStart);
        logic [15:0] expHi, expLo, gotHi, gotLo, prev;
        logic [3:0]  expFlg, gotFlg;
        bit          twoWords;
        int          lat, seen;
        model(op, m, q, expHi, expLo, expFlg, twoWords, lat);
        seen = 0; gotHi = 16'hxxxx; gotLo = 16'hxxxx; gotFlg = 4'hx; prev = 16'h0000;
        @(posedge clk); #1; start = 1'b1; s = op; inbus = 16'($urandom);
        @(posedge clk); #1; start = 1'b0; s = 4'($urandom); inbus = m;
        @(posedge clk); #1; inbus = q; s = 4'($urandom);
        @(posedge clk); #1; inbus = 16'($urandom);
        for (int k = 1; k <= 30 && seen == 0; k++) begin
            @(negedge clk);
            start = (pokeStart && twoWords && k < 10) ? 1'($urandom) : 1'b0;
            s     = 4'($urandom);
            inbus = 16'($urandom);
            if (finish) begin
                seen   = k;
                gotLo  = outbus;
                gotHi  = prev;
                gotFlg = {negative, zero, carry, overflow};
            end
            prev = outbus;
        end
        start = 1'b0;
        checkOutput($sformatf("%s latency", name), 32'(seen), 32'(lat));
        checkOutput($sformatf("%s lo word", name), {16'd0, gotLo}, {16'd0, expLo});
        checkOutput($sformatf("%s %s", name, twoWords ? "hi word" : "pre word"), {16'd0, gotHi}, {16'd0, expHi});
        checkOutput($sformatf("%s flags NZCV", name), {28'd0, gotFlg}, {28'd0, expFlg});
        @(negedge clk);
        checkOutput($sformatf("%s post finish/outbus", name), {15'd0, finish, outbus}, 32'd0);
    endtask

    initial begin
        int nFin;
        logic [3:0] op;
        rst_b = 1'b0; start = 1'b0; s = 4'd0; inbus = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset outbus/finish", {15'd0, finish, outbus}, 32'd0);
        checkOutput("reset flags", {28'd0, negative, zero, carry, overflow}, 32'd0);
        @(posedge clk); #1; rst_b = 1'b1;

        applyStimulus("add 0863+0005", 4'd0, 16'h0863, 16'h0005, 1'b0);
        applyStimulus("sub 0863-0005", 4'd1, 16'h0005, 16'h0863, 1'b0);
        applyStimulus("sub 8000-0001", 4'd1, 16'h0001, 16'h8000, 1'b0);
        applyStimulus("add ovf", 4'd0, 16'd16389, 16'd16386, 1'b0);
        applyStimulus("add carry zero", 4'd0, 16'hFFFF, 16'h0001, 1'b0);
        applyStimulus("mul 2147x5", 4'd2, 16'd2147, 16'd5, 1'b1);
        applyStimulus("mul min x min", 4'd2, 16'h8000, 16'h8000, 1'b0);
        applyStimulus("mul neg", 4'd2, 16'hFFFD, 16'd7, 1'b0);
        applyStimulus("div 18921/145", 4'd3, 16'd145, 16'd18921, 1'b1);
        applyStimulus("div by zero", 4'd3, 16'd0, 16'd7, 1'b0);
        applyStimulus("reserved 0111", 4'd7, 16'h1234, 16'h5678, 1'b0);
        applyStimulus("mul 2350x159", 4'd2, 16'd2350, 16'd159, 1'b0);

        // Abort a multiply mid-iteration; flags from the previous product must be cleared.
        @(posedge clk); #1; start = 1'b1; s = 4'd2;
        @(posedge clk); #1; start = 1'b0; inbus = 16'd2350;
        @(posedge clk); #1; inbus = 16'd159;
        repeat (6) @(posedge clk);
        #1; rst_b = 1'b0;
        @(posedge clk); #1; rst_b = 1'b1;
        @(negedge clk);
        checkOutput("abort outbus/finish", {15'd0, finish, outbus}, 32'd0);
        checkOutput("abort flags", {28'd0, negative, zero, carry, overflow}, 32'd0);
        nFin = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (finish) nFin++;
        end
        checkOutput("abort no finish", 32'(nFin), 32'd0);
        applyStimulus("add after abort", 4'd0, 16'h0863, 16'h0005, 1'b0);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 4));
            if (op == 4'd4) op = 4'($urandom_range(4, 15));
            applyStimulus($sformatf("rand%0d op%0d", i, op), op, 16'($urandom), 16'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
